mrr_bit_slicer: RTL
===================

# mrr_bit_slicer

Downstream stage of the MRR correlator. Once the correlator asserts `syncd_flag`, this block treats the power-domain sample stream (framed by `i_tkeep`) as a symbol-synchronous pulse train. It then:
- peak-searches a jitter window at the start of every symbol;
- derives a slicing threshold from the trailing header pulses;
- verifies the 15-bit PN sequence;
- emits hard-decision payload bits to the packet decoder.

## Interface
Parameters:
- `ESAMP_WIDTH`, 16, power-sample width.
- `OVERSAMPLING_RATIO_LOG2`, 2, log2 of samples per chip.
- `PN_LEN`, 15, PN sequence length.
- `PN_SEQ`, 15'b000100110101111, expected PN bits, MSB first.
- `PN_MAX_ERR`, 1, tolerated PN bit mismatches.
- `NUM_TRAIN_LOG2`, 3, log2 of header pulses averaged for the threshold (8).
- `PAYLOAD_LEN_WIDTH`, 12, width of `payload_len`.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-low reset.
- `i_tdata` in `ESAMP_WIDTH`: power sample.
- `i_tvalid` in 1: sample valid.
- `i_tkeep` in 1: resampled-sample marker. A strobe is `i_tvalid & i_tkeep`.
- `syncd_flag` in 1: from the correlator, high at the first synchronized symbol start.
- `i_abort` in 1: synchronous abort to IDLE.
- `recharge_len` in 15: symbol recharge length in chips.
- `max_jitter` in 8: half-width of the peak window, in samples.
- `payload_len` in `PAYLOAD_LEN_WIDTH`: payload bits to emit.
- `o_bit` out 1: sliced bit.
- `o_bit_valid` out 1: one-cycle qualifier for `o_bit`.
- `o_bit_last` out 1: marks the final payload bit.
- `o_pn_locked` out 1: one-cycle pulse when the PN check passes.
- `o_pn_fail` out 1: one-cycle pulse when the PN check fails.
- `o_busy` out 1: high in any state other than IDLE.
- `o_thresh` out `ESAMP_WIDTH`: current threshold, for debug.

## Operation
- Symbol period `P = (recharge_len + 2) << OVERSAMPLING_RATIO_LOG2` strobes, computed in 18 bits.
- A symbol counter `sc` counts strobes `0..P-1` and wraps. The peak window is `sc ∈ [0, W]`, where `W = min(2*max_jitter, P-1)`.
- The peak register keeps the maximum `i_tdata` seen in the window. It reloads on `sc == 0`. Ties keep the earliest sample.
- Window close is the strobe with `sc == W`. It produces a peak decision. Bit = 1 if `peak <= thresh`, else 0. A pulse present therefore decodes as 0, consistent with the all-zero header.
- States:
  - IDLE: rising edge of `syncd_flag` loads `sc = 0`, clears the accumulator, and goes to TRAIN.
  - TRAIN: each window close adds `peak` to `acc` (`ESAMP_WIDTH + NUM_TRAIN_LOG2` bits, saturating). After `2^NUM_TRAIN_LOG2` closes, set `thresh = acc >> (NUM_TRAIN_LOG2 + 1)` (half the mean peak) and go to PN. No bits are output in TRAIN.
  - PN: slice `PN_LEN` bits and compare each to `PN_SEQ[PN_LEN-1-i]`, counting mismatches. After the last bit:
    - mismatches ≤ `PN_MAX_ERR`: pulse `o_pn_locked`, then go to PAYLOAD, or to DONE if `payload_len == 0`.
    - otherwise: pulse `o_pn_fail` and go to IDLE.
    - PN bits are not output on `o_bit`.
  - PAYLOAD: each decision drives `o_bit` / `o_bit_valid`. The `payload_len`-th bit also asserts `o_bit_last`, then the block goes to DONE.
  - DONE: waits for `syncd_flag` low, then goes to IDLE.
- `i_abort` in any state forces IDLE next cycle. It clears the counters and suppresses any decision issued in that cycle. `thresh` is retained for debug.
- A `syncd_flag` rising edge outside IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `sc`, `acc`, `peak`, `thresh` all 0.
- Decision latency: `o_bit_valid` asserts exactly 1 cycle after the window-close strobe. `o_pn_locked` / `o_pn_fail` assert 1 cycle after the last PN window-close strobe.
- No backpressure: the consumer must accept every `o_bit_valid` pulse. Strobes may be non-contiguous, and all counters advance only on strobes.
- `recharge_len`, `max_jitter`, and `payload_len` are sampled into registers on the IDLE→TRAIN transition and held until IDLE.
- Boundary behaviour:
  - `max_jitter == 0`: a single-sample window at `sc == 0`.
  - `2*max_jitter ≥ P`: clamp `W` to `P-1`.
  - Window close coinciding with the `sc` wrap: the decision for the current symbol completes before the new window reloads.
  - Abort and window close in the same cycle: abort wins, and no decision is issued.

## Structure
- Shared in `mrr_params.vh`: `ESAMP_WIDTH`, `OVERSAMPLING_RATIO_LOG2`, `PN_SEQ`, `PN_LEN`, and the state encodings IDLE=0, TRAIN=1, PN=2, PAYLOAD=3, DONE=4.
- Sub-module `mrr_peak_window`: symbol counter, window bound clamp, and peak tracker. It outputs `peak` plus a one-cycle `win_close` pulse.
- Top level: FSM, threshold accumulator, PN comparator, and payload counter.

## Test plan
- Reset mid-PAYLOAD (`rst` low for 1 cycle) → all outputs 0 and `o_busy` 0 in the same cycle; the next `syncd_flag` edge restarts cleanly in TRAIN.
- Nominal: `recharge_len=32` (P=136), `max_jitter=4`, header pulses of 1000 on 0-noise, correct PN, `payload_len=8` with payload 10110010 → `thresh=500`, one `o_pn_locked` pulse, 8 bits 10110010, `o_bit_last` on the 8th bit.
- PN with 2 flipped bits (`PN_MAX_ERR=1`) → `o_pn_fail` pulse 1 cycle after the 15th window close, no `o_bit_valid`, return to IDLE.
- Pulse jittered +3 then −3 samples and peak ties → earliest peak chosen, all bits correct; with `max_jitter=0` and a pulse at offset 1 → bit decodes 1.
- Strobes gated 1-in-3 via `i_tkeep` → identical bit output to the contiguous run, with counters advancing only on strobes.
- `i_abort` asserted on the same cycle as the 3rd payload window close → no 3rd bit, IDLE next cycle, `o_busy` 0; `payload_len=0` run → `o_pn_locked` then DONE with no bits output.

Source files
------------

// File: rtl/mrr_bit_slicer_pkg.sv
// Shared types and defaults for the MRR bit slicer.
// State encodings match the correlator-side debug decoder.
package mrr_bit_slicer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRAIN   = 3'd1,
        PN      = 3'd2,
        PAYLOAD = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int          DEF_ESAMP_WIDTH = 16;
    localparam int          DEF_OSR_LOG2    = 2;
    localparam int          DEF_PN_LEN      = 15;
    localparam logic [14:0] DEF_PN_SEQ      = 15'b000100110101111;
    localparam int          PERIOD_WIDTH    = 18;
    localparam int          CNT_WIDTH       = 16;

endpackage

// File: rtl/mrr_bit_slicer_peak_window.sv
// Symbol counter, clamped jitter window and peak tracker.
// peak is the running maximum including the current sample.
module mrr_bit_slicer_peak_window #(
    parameter int DW = 16,
    parameter int PW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          strobe,
    input  logic          run,
    input  logic          clear,
    input  logic [PW-1:0] period,
    input  logic [7:0]    max_jitter,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] peak,
    output logic          win_close
);

    logic [PW-1:0] sc;
    logic [PW-1:0] jit2;
    logic [PW-1:0] win_end;
    logic [DW-1:0] peak_q;
    logic          in_win;

    assign jit2    = {{(PW-9){1'b0}}, max_jitter, 1'b0};
    assign win_end = (jit2 >= period) ? period - PW'(1) : jit2;
    assign in_win  = (sc <= win_end);

    // Strict compare: a later equal sample never displaces the earlier one.
    assign peak = ((sc == '0) || (data > peak_q)) ? data : peak_q;

    assign win_close = strobe & run & (sc == win_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc     <= '0;
            peak_q <= '0;
        end else if (clear) begin
            sc     <= '0;
        end else if (strobe && run) begin
            sc <= (sc == period - PW'(1)) ? '0 : sc + PW'(1);
            if (in_win) begin
                peak_q <= peak;
            end
        end
    end

endmodule

// File: rtl/mrr_bit_slicer.sv
// MRR bit slicer: header training, PN verification and payload slicing
// of the synchronized power-sample pulse train.
module mrr_bit_slicer
    import mrr_bit_slicer_pkg::*;
#(
    parameter int                   ESAMP_WIDTH             = DEF_ESAMP_WIDTH,
    parameter int                   OVERSAMPLING_RATIO_LOG2 = DEF_OSR_LOG2,
    parameter int                   PN_LEN                  = DEF_PN_LEN,
    parameter logic [PN_LEN-1:0]    PN_SEQ                  = DEF_PN_SEQ,
    parameter int                   PN_MAX_ERR              = 1,
    parameter int                   NUM_TRAIN_LOG2          = 3,
    parameter int                   PAYLOAD_LEN_WIDTH       = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ESAMP_WIDTH-1:0]       i_tdata,
    input  logic                         i_tvalid,
    input  logic                         i_tkeep,
    input  logic                         syncd_flag,
    input  logic                         i_abort,
    input  logic [14:0]                  recharge_len,
    input  logic [7:0]                   max_jitter,
    input  logic [PAYLOAD_LEN_WIDTH-1:0] payload_len,
    output logic                         o_bit,
    output logic                         o_bit_valid,
    output logic                         o_bit_last,
    output logic                         o_pn_locked,
    output logic                         o_pn_fail,
    output logic                         o_busy,
    output logic [ESAMP_WIDTH-1:0]       o_thresh
);

    localparam int PW    = PERIOD_WIDTH;
    localparam int CW    = CNT_WIDTH;
    localparam int ACC_W = ESAMP_WIDTH + NUM_TRAIN_LOG2;
    localparam int ERR_W = $clog2(PN_LEN + 1);
    localparam int SH    = NUM_TRAIN_LOG2 + 1;

    state_t state, state_n;

    logic                         syncd_d;
    logic [14:0]                  rl_q;
    logic [7:0]                   mj_q;
    logic [PAYLOAD_LEN_WIDTH-1:0] pl_q;
    logic [ACC_W-1:0]             acc;
    logic [ESAMP_WIDTH-1:0]       thresh;
    logic [CW-1:0]                cnt;
    logic [ERR_W-1:0]             err;
    logic [PN_LEN-1:0]            pn_sr;

    logic                   strobe, rise, run, clear;
    logic                   win_close, close, dec;
    logic [ESAMP_WIDTH-1:0] peak;
    logic [PW-1:0]          period;
    logic [ACC_W:0]         acc_sum;
    logic [ACC_W-1:0]       acc_nxt;
    logic [ERR_W-1:0]       err_nxt;
    logic                   pn_ok;
    logic                   last_train, last_pn, last_pay;

    logic load_cfg, cnt_clr, acc_add, thr_set;
    logic pn_step, pay_step, bit_l, lock, fail;

    assign strobe = i_tvalid & i_tkeep;
    assign rise   = syncd_flag & ~syncd_d;
    assign run    = state inside {TRAIN, PN, PAYLOAD};
    assign period = (PW'(rl_q) + PW'(2)) << OVERSAMPLING_RATIO_LOG2;
    assign clear  = i_abort | load_cfg;

    mrr_bit_slicer_peak_window #(
        .DW (ESAMP_WIDTH),
        .PW (PW)
    ) u_win (
        .clk        (clk),
        .rst        (rst),
        .strobe     (strobe),
        .run        (run),
        .clear      (clear),
        .period     (period),
        .max_jitter (mj_q),
        .data       (i_tdata),
        .peak       (peak),
        .win_close  (win_close)
    );

    // A pulse in the window is a 0; silence is a 1.
    assign close = win_close & ~i_abort;
    assign dec   = (peak <= thresh);

    assign acc_sum = {1'b0, acc} + (ACC_W+1)'(peak);
    assign acc_nxt = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    assign err_nxt = err + ERR_W'(dec != pn_sr[PN_LEN-1]);
    assign pn_ok   = (err_nxt <= ERR_W'(PN_MAX_ERR));

    assign last_train = (cnt == CW'((1 << NUM_TRAIN_LOG2) - 1));
    assign last_pn    = (cnt == CW'(PN_LEN - 1));
    assign last_pay   = ((cnt + CW'(1)) == CW'(pl_q));

    always_comb begin
        state_n  = state;
        load_cfg = 1'b0;
        cnt_clr  = 1'b0;
        acc_add  = 1'b0;
        thr_set  = 1'b0;
        pn_step  = 1'b0;
        pay_step = 1'b0;
        bit_l    = 1'b0;
        lock     = 1'b0;
        fail     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n  = TRAIN;
                    load_cfg = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            TRAIN: begin
                if (close) begin
                    acc_add = 1'b1;
                    if (last_train) begin
                        thr_set = 1'b1;
                        cnt_clr = 1'b1;
                        state_n = PN;
                    end
                end
            end
            PN: begin
                if (close) begin
                    pn_step = 1'b1;
                    if (last_pn) begin
                        cnt_clr = 1'b1;
                        if (pn_ok) begin
                            lock    = 1'b1;
                            state_n = (pl_q == '0) ? DONE : PAYLOAD;
                        end else begin
                            fail    = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (close) begin
                    pay_step = 1'b1;
                    if (last_pay) begin
                        bit_l   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (!syncd_flag) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (i_abort) begin
            state_n  = IDLE;
            load_cfg = 1'b0;
            cnt_clr  = 1'b1;
            acc_add  = 1'b0;
            thr_set  = 1'b0;
            pn_step  = 1'b0;
            pay_step = 1'b0;
            bit_l    = 1'b0;
            lock     = 1'b0;
            fail     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncd_d     <= 1'b0;
            rl_q        <= '0;
            mj_q        <= '0;
            pl_q        <= '0;
            acc         <= '0;
            thresh      <= '0;
            cnt         <= '0;
            err         <= '0;
            pn_sr       <= '0;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
            o_bit_last  <= 1'b0;
            o_pn_locked <= 1'b0;
            o_pn_fail   <= 1'b0;
        end else begin
            syncd_d <= syncd_flag;
            if (load_cfg) begin
                rl_q  <= recharge_len;
                mj_q  <= max_jitter;
                pl_q  <= payload_len;
                acc   <= '0;
                err   <= '0;
                pn_sr <= PN_SEQ;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (acc_add || pn_step || pay_step) begin
                cnt <= cnt + CW'(1);
            end
            if (acc_add) begin
                acc <= acc_nxt;
            end
            if (thr_set) begin
                thresh <= {1'b0, acc_nxt[ACC_W-1:SH]};
            end
            if (pn_step) begin
                err   <= err_nxt;
                pn_sr <= {pn_sr[PN_LEN-2:0], 1'b0};
            end
            o_bit       <= pay_step & dec;
            o_bit_valid <= pay_step;
            o_bit_last  <= bit_l;
            o_pn_locked <= lock;
            o_pn_fail   <= fail;
        end
    end

    assign o_busy   = (state != IDLE);
    assign o_thresh = thresh;

endmodule
